conv1d_cmd_sequencer: RTL
=========================

# conv1d_cmd_sequencer

Hardware initiator for the conv1d CFU command interface: it drives `cmd`/`inp0`/`inp1` in place of the CPU. It streams input-buffer rows and kernel rows into the accelerator, sets the bias, issues start, waits for `output_buffer_valid`, and reads the results back into a ready/valid result stream. It sits between a DMA-style word source and conv1d, so layers can run without per-word CPU commands.

## Interface
- `ROW_STRIDE`, 128: row pitch of the input and kernel buffers; row r maps to address r*ROW_STRIDE, column 0.
- `KERNEL_LEN`, 8: kernel rows written per job.
- `CNT_W`, 11: width of the row and output counters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle job request; sampled only in IDLE.
- `num_rows` in CNT_W: input rows, padding included; latched at start.
- `num_out` in CNT_W: output words to read back; latched at start.
- `bias` in 32: latched at start.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 32: word stream carrying num_rows input words, then KERNEL_LEN kernel words. Each word holds 4 int8 channels, MSB byte = channel 0.
- `cmd` out 7, `inp0` out 32, `inp1` out 32: conv1d command port.
- `cfu_ret` in 32: conv1d `ret`.
- `cfu_out_valid` in 1: conv1d `output_buffer_valid`.
- `res_valid` out 1, `res_ready` in 1, `res_data` out 32: result stream.
- `busy` out 1: high from the cycle after an accepted start until DONE.
- `done` out 1: one-cycle pulse in DONE.

## Operation
Command codes driven on `cmd`:
- 0 = idle
- 1 = write input
- 2 = write kernel
- 3 = read output
- 4 = start
- 7 = set bias

All outputs are registered. Reset values: `cmd`=0, `inp0`=0, `inp1`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `busy`=0, `done`=0, state = IDLE, all counters 0.

State machine:
- IDLE: on `start`=1, latch num_rows, num_out and bias; clear counters; go to LOAD_IN. If num_rows=0, go directly to LOAD_K.
- LOAD_IN: `in_ready`=1. Each accepted word with row counter r drives `cmd`=1, `inp0`=r*ROW_STRIDE, `inp1`=in_data for exactly one cycle. Cycles with no handshake drive `cmd`=0. After row num_rows-1, go to LOAD_K.
- LOAD_K: same as LOAD_IN with `cmd`=2 and r counting 0..KERNEL_LEN-1; then go to BIAS.
- BIAS: `cmd`=7, `inp0`=bias for one cycle; go to GO.
- GO: `cmd`=4 for one cycle; go to WAIT.
- WAIT: `cmd`=0. Leave when `cfu_out_valid`=1: go to RD if num_out>0, else go to DONE.
- RD: `cmd`=3, `inp0`=k*4 (byte address of output k) for one cycle; go to CAP.
- CAP: `cmd`=0; register `res_data`=cfu_ret; set `res_valid`=1; go to PUSH.
- PUSH: hold `res_data` and `res_valid` until `res_ready`=1. On that handshake, k++. If k=num_out then go to DONE, else go to RD.
- DONE: `done`=1 for one cycle; `busy`=0; return to IDLE.

Rules:
- Address arithmetic is 32-bit unsigned, truncated with no saturation. Input rows above 2^32/ROW_STRIDE wrap, and this is the caller's responsibility.
- `start` outside IDLE is ignored, with no queuing.
- `in_ready` is 0 in every state except LOAD_IN and LOAD_K.
- Words offered beyond the job's count are not consumed.
- `reset_n`=0 in any state forces every output to its reset value on the next edge and aborts the job. No partial result is emitted.

## Timing
- Write throughput: one input or kernel word per cycle while `in_valid` is held high. A stalled stream produces `cmd`=0 bubbles with no ordering change.
- Minimum job latency from start to done: num_rows + KERNEL_LEN + 3 (IDLE→BIAS→GO→WAIT) + wait time + 3·num_out + 1 cycles, with `res_ready` held high.
- `cfu_ret` is sampled exactly one cycle after the RD command cycle.
- Back-to-back results are at least 3 cycles apart. At most one read is outstanding, so backpressure never loses data.
- `cfu_out_valid` already high on WAIT entry is accepted in that same cycle. The block never waits less than one cycle after GO.
- A simultaneous `res_ready` and reset: reset wins, and the result is not counted.

## Test plan
- Nominal job: num_rows=16, 4 zero rows, data rows 0x07000000, 0x06010000 … 0x00070000, 4 zero rows; 8 kernel words 0x02010000; bias=1; num_out=8 → required trace:
  - `cmd`=1 with `inp0`=0,128,…,1920;
  - `cmd`=2 with `inp0`=0..896;
  - `cmd`=7 with `inp0`=1;
  - `cmd`=4;
  - `cmd`=3 with `inp0`=0,4,…,28.
  
  The 8 results must match the conv1d model output in order, and `done` pulses once.
- Input stall: deassert `in_valid` every other cycle → `cmd`=0 in gap cycles; address sequence identical to the nominal job.
- Result backpressure: hold `res_ready`=0 for 10 cycles on result 2 → `res_data` stable, no new `cmd`=3 issued, all 8 results delivered.
- Edge counts: num_rows=0 with num_out=0 → only kernel writes, bias, start, then done once `cfu_out_valid` rises, with no `cmd`=3 issued.
- Reset mid-LOAD_K: `reset_n`=0 for one cycle → next cycle `cmd`=0, `busy`=0, `in_ready`=0. A new start then replays from row 0.
- Start while busy: pulse `start` during WAIT → ignored, and latched num_out/bias are unchanged.

Source files
------------

// File: rtl/conv1d_cmd_sequencer.sv
// conv1d_cmd_sequencer: streams rows, kernel and bias into conv1d, starts it, and reads the outputs back as a result stream
module conv1d_cmd_sequencer #(
  parameter int ROW_STRIDE = 128,
  parameter int KERNEL_LEN = 8,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic [CNT_W-1:0] num_out,
  input  logic [31:0]      bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [6:0]       cmd,
  output logic [31:0]      inp0,
  output logic [31:0]      inp1,
  input  logic [31:0]      cfu_ret,
  input  logic             cfu_out_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             done
);
  typedef enum logic [3:0] {IDLE, LOAD_IN, LOAD_K, BIAS, GO, WAIT, RD, CAP, PUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] nrows_q, nrows_d, nout_q, nout_d, row_q, row_d, k_q, k_d;
  logic [31:0] bias_q, bias_d, inp0_q, inp0_d, inp1_q, inp1_d, res_data_q, res_data_d;
  logic [6:0] cmd_q, cmd_d;
  logic in_ready_q, in_ready_d, res_valid_q, res_valid_d, busy_q, busy_d, done_q, done_d, last;
  assign cmd = cmd_q;
  assign inp0 = inp0_q;
  assign inp1 = inp1_q;
  assign in_ready = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    nrows_d = nrows_q;
    nout_d = nout_q;
    bias_d = bias_q;
    row_d = row_q;
    k_d = k_q;
    cmd_d = 7'd0;
    inp0_d = inp0_q;
    inp1_d = inp1_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    last = (state_q == LOAD_IN) ? row_q == nrows_q - 1'b1 : row_q == CNT_W'(KERNEL_LEN - 1);
    case (state_q)
      IDLE: if (start) begin
        nrows_d = num_rows;
        nout_d = num_out;
        bias_d = bias;
        row_d = '0;
        k_d = '0;
        state_d = (num_rows == '0) ? LOAD_K : LOAD_IN;
      end
      LOAD_IN, LOAD_K: if (in_valid && in_ready_q) begin
        cmd_d = (state_q == LOAD_IN) ? 7'd1 : 7'd2;
        inp0_d = 32'(row_q) * 32'(ROW_STRIDE);
        inp1_d = in_data;
        row_d = last ? '0 : row_q + 1'b1;
        state_d = !last ? state_q : (state_q == LOAD_IN) ? LOAD_K : BIAS;
      end
      BIAS: begin
        cmd_d = 7'd7;
        inp0_d = bias_q;
        state_d = GO;
      end
      GO: begin
        cmd_d = 7'd4;
        state_d = WAIT;
      end
      WAIT: if (cfu_out_valid) state_d = (nout_q != '0) ? RD : DONE;
      RD: begin
        cmd_d = 7'd3;
        inp0_d = 32'(k_q) << 2;
        state_d = CAP;
      end
      CAP: begin
        res_data_d = cfu_ret;
        res_valid_d = 1'b1;
        state_d = PUSH;
      end
      PUSH: if (res_ready) begin
        res_valid_d = 1'b0;
        k_d = k_q + 1'b1;
        state_d = (k_q + 1'b1 == nout_q) ? DONE : RD;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == LOAD_IN || state_d == LOAD_K;
    busy_d = state_d != IDLE && state_d != DONE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      nrows_q <= '0;
      nout_q <= '0;
      bias_q <= '0;
      row_q <= '0;
      k_q <= '0;
      cmd_q <= '0;
      inp0_q <= '0;
      inp1_q <= '0;
      in_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nrows_q <= nrows_d;
      nout_q <= nout_d;
      bias_q <= bias_d;
      row_q <= row_d;
      k_q <= k_d;
      cmd_q <= cmd_d;
      inp0_q <= inp0_d;
      inp1_q <= inp1_d;
      in_ready_q <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
